// File: rtl/csel_pipe_addsub.sv
// Two-stage pipelined carry-select adder/subtractor with optional signed saturation.
// The low half is added in stage 1. The high half, overflow and saturation are resolved in stage 2.
module csel_pipe_addsub #(
   parameter int WIDTH = 16,
   parameter int BLK   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   // WIDTH must be a multiple of 2*BLK so that each half splits into whole blocks.
   localparam int HALF = WIDTH / 2;
   localparam int NBLK = HALF / BLK;

   // Generate/propagate lookahead for the first block, which has a known carry-in.
   function automatic logic [BLK:0] cla_blk(input logic [BLK-1:0] x, input logic [BLK-1:0] y,
                                            input logic ci);
      logic [BLK-1:0] g;
      logic [BLK-1:0] p;
      logic [BLK:0]   c;
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < BLK; i++) c[i+1] = g[i] | (p[i] & c[i]);
      return {c[BLK], p ^ c[BLK-1:0]};
   endfunction

   // Later blocks precompute both carry-in cases, then select on the previous block's carry.
   function automatic logic [HALF:0] csel_half(input logic [HALF-1:0] x, input logic [HALF-1:0] y,
                                               input logic ci);
      logic [HALF-1:0] s;
      logic            c;
      logic [BLK:0]    r;
      logic [BLK:0]    r0;
      logic [BLK:0]    r1;
      s  = '0;
      r0 = '0;
      r1 = '0;
      r  = cla_blk(x[BLK-1:0], y[BLK-1:0], ci);
      s[BLK-1:0] = r[BLK-1:0];
      c  = r[BLK];
      for (int k = 1; k < NBLK; k++) begin
         r0 = {1'b0, x[k*BLK +: BLK]} + {1'b0, y[k*BLK +: BLK]};
         r1 = {1'b0, x[k*BLK +: BLK]} + {1'b0, y[k*BLK +: BLK]} + (BLK+1)'(1);
         r  = c ? r1 : r0;
         s[k*BLK +: BLK] = r[BLK-1:0];
         c  = r[BLK];
      end
      return {c, s};
   endfunction

   logic [WIDTH-1:0] bb;
   logic [HALF:0]    lo_res;
   logic             load;
   logic             adv2;

   logic             s1_v;
   logic [HALF-1:0]  s1_lo;
   logic             s1_c;
   logic [HALF-1:0]  s1_ahi;
   logic [HALF-1:0]  s1_bhi;
   logic             s1_amsb;
   logic             s1_sat;

   logic [HALF:0]    hi_res;
   logic [WIDTH-1:0] raw;
   logic             ovf_c;
   logic [WIDTH-1:0] sum_c;

   // Handshake: a stage advances only when the stage downstream is empty or draining this cycle.
   assign adv2     = s1_v && (!out_valid || out_ready);
   assign in_ready = !s1_v || adv2;
   assign load     = in_valid && in_ready;

   assign bb     = sub ? ~b : b;
   assign lo_res = csel_half(a[HALF-1:0], bb[HALF-1:0], sub);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
      end else if (load) begin
         s1_v <= 1'b1;
      end else if (adv2) begin
         s1_v <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_lo   <= '0;
         s1_c    <= 1'b0;
         s1_ahi  <= '0;
         s1_bhi  <= '0;
         s1_amsb <= 1'b0;
         s1_sat  <= 1'b0;
      end else if (load) begin
         s1_lo   <= lo_res[HALF-1:0];
         s1_c    <= lo_res[HALF];
         s1_ahi  <= a[WIDTH-1:HALF];
         s1_bhi  <= bb[WIDTH-1:HALF];
         s1_amsb <= a[WIDTH-1];
         s1_sat  <= sat;
      end
   end

   assign hi_res = csel_half(s1_ahi, s1_bhi, s1_c);
   assign raw    = {hi_res[HALF-1:0], s1_lo};
   assign ovf_c  = (s1_amsb == s1_bhi[HALF-1]) && (raw[WIDTH-1] != s1_amsb);

   always_comb begin
      sum_c = raw;
      if (s1_sat && ovf_c) begin
         sum_c = s1_amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else if (adv2) begin
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else if (adv2) begin
         sum  <= sum_c;
         cout <= hi_res[HALF];
         ovf  <= ovf_c;
      end
   end

endmodule

// File: tb/tb_csel_pipe_addsub.sv
// Directed bench for csel_pipe_addsub: 16-bit instance for handshake/modes, 32-bit instance for block carries.
module tb_csel_pipe_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, sum;
   logic        sub, sat, cout, ovf;

   logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
   logic [31:0] a_w, b_w, sum_w;
   logic        sub_w, sat_w, cout_w, ovf_w;

   csel_pipe_addsub #(.WIDTH(16), .BLK(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf));

   csel_pipe_addsub #(.WIDTH(32), .BLK(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
      .a(a_w), .b(b_w), .sub(sub_w), .sat(sat_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
      .sum(sum_w), .cout(cout_w), .ovf(ovf_w));

   int checks = 0;
   int failures = 0;
   int got_n = 0;
   int busy_n = 0;
   int got0;
   logic [17:0] exp_q[$];
   logic [17:0] mon_e;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} from plain integer arithmetic.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic s, input logic t);
      logic [15:0] yy;
      logic [16:0] r;
      logic        v;
      logic [15:0] o;
      yy = s ? ~y : y;
      r  = {1'b0, x} + {1'b0, yy} + {16'd0, s};
      v  = (x[15] == yy[15]) && (r[15] != x[15]);
      o  = (t && v) ? (x[15] ? 16'h8000 : 16'h7FFF) : r[15:0];
      return {v, r[16], o};
   endfunction

   task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                       input logic vt, input logic [17:0] e);
      int n;
      a = va; b = vb; sub = vs; sat = vt; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         busy_n++;
         n++;
         @(negedge clk);
      end
      if (!in_ready) check("send_timeout", 64'd0, 64'd1);
      else exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         n++;
         @(posedge clk);
      end
      #1;
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_w(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vs, input logic [31:0] es, input logic ec);
      int n;
      a_w = va; b_w = vb; sub_w = vs; sat_w = 1'b0; in_valid_w = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready_w && n < 20) begin
         n++;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid_w = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid_w && n < 20) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_ov"}, 64'(out_valid_w), 64'd1);
      check({tag, "_sum"}, 64'(sum_w), 64'(es));
      check({tag, "_cout"}, 64'(cout_w), 64'(ec));
      check({tag, "_ovf"}, 64'(ovf_w), 64'd0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("result", 64'({ovf, cout, sum}), 64'(mon_e));
            got_n++;
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0; sat = 1'b0;
      in_valid_w = 1'b0; out_ready_w = 1'b1; a_w = '0; b_w = '0; sub_w = 1'b0; sat_w = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Wrap-around add and two-cycle latency
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
      in_valid = 1'b0;
      check("lat1_n1", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("lat1_n2", 64'(out_valid), 64'd1);

      // Directed back-to-back beats, mode bits changing per beat
      send(16'h0005, 16'h0007, 1'b1, 1'b0, {1'b0, 1'b0, 16'hFFFE});
      send(16'h0007, 16'h0005, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0002});
      send(16'h7FFF, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b0, 16'h7FFF});
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
      send(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h8000});
      send(16'h1234, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h1234});
      send(16'h1000, 16'h2000, 1'b0, 1'b1, {1'b0, 1'b0, 16'h3000});
      send(16'h8000, 16'hFFFF, 1'b0, 1'b1, {1'b1, 1'b1, 16'h8000});
      in_valid = 1'b0;
      drain();

      // Streaming with a free-running consumer: in_ready never drops
      busy_n = 0;
      for (int i = 0; i < 8; i++) begin
         logic [15:0] ra, rb;
         logic        rs, rt;
         ra = 16'($urandom_range(0, 16'hFFFF));
         rb = 16'($urandom_range(0, 16'hFFFF));
         rs = 1'($urandom_range(0, 1));
         rt = 1'($urandom_range(0, 1));
         send(ra, rb, rs, rt, model(ra, rb, rs, rt));
      end
      in_valid = 1'b0;
      check("stream_no_stall", 64'(busy_n), 64'd0);
      drain();

      // Consumer stall mid-stream
      got0 = got_n;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               logic [15:0] ra, rb;
               ra = 16'($urandom_range(0, 16'hFFFF));
               rb = 16'($urandom_range(0, 16'hFFFF));
               send(ra, rb, 1'(i % 2), 1'b1, model(ra, rb, 1'(i % 2), 1'b1));
            end
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            check("stall_ov", 64'(out_valid), 64'd1);
            check("stall_sum1", 64'(sum), 64'(exp_q[0][15:0]));
            @(negedge clk);
            check("stall_sum2", 64'({ovf, cout, sum}), 64'(exp_q[0]));
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
            check("stall_sum3", 64'(sum), 64'(exp_q[0][15:0]));
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check("stall_count", 64'(got_n - got0), 64'd6);

      // Reset with both stages occupied
      out_ready = 1'b0;
      send(16'h0101, 16'h0202, 1'b0, 1'b0, {2'b00, 16'h0303});
      send(16'h0303, 16'h0404, 1'b0, 1'b0, {2'b00, 16'h0707});
      in_valid = 1'b0;
      @(negedge clk);
      check("full_ov", 64'(out_valid), 64'd1);
      check("full_in_ready", 64'(in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ov", 64'(out_valid), 64'd0);
      check("mid_rst_sum", 64'(sum), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      send(16'h1234, 16'h1111, 1'b0, 1'b0, {2'b00, 16'h2345});
      in_valid = 1'b0;
      check("post_rst_n1", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("post_rst_n2", 64'(out_valid), 64'd1);
      drain();

      // 32-bit instance: carries through every block and across the stage split
      run_w("w_carry", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0);
      run_w("w_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
      run_w("w_borrow", 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
